alu_cmd_unit: RTL and testbench
===============================

ALU_CMD_UNIT -- requirements
Module: alu_cmd_unit

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the command FIFO entry count; legal values are 2, 4 and 8.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port cmd_valid, input, 1 bit: a command is offered.
REQ-005 SHALL have port cmd_ready, output, 1 bit: the unit can accept a command.
REQ-006 SHALL have port cmd_a, input, 4 bits: operand A.
REQ-007 SHALL have port cmd_b, input, 4 bits: operand B.
REQ-008 SHALL have port cmd_sel, input, 3 bits: operation select.
REQ-009 SHALL have port res_valid, output, 1 bit: the result register holds an unconsumed result.
REQ-010 SHALL have port res_ready, input, 1 bit: the consumer takes the result.
REQ-011 SHALL have port res_y, output, 4 bits: the result value.
REQ-012 SHALL have port res_carry, output, 1 bit: carry or borrow of the result.
REQ-013 SHALL have port res_sel, output, 3 bits: echo of the sel that produced the result.
REQ-014 SHALL have port level, output, 4 bits: current FIFO occupancy.
REQ-015 SHALL have port op_count, output, 8 bits: count of results consumed.

Function
REQ-016 SHALL accept a command on a rising edge where cmd_valid and cmd_ready are both 1; the command {a, b, sel} is written to the FIFO tail.
REQ-017 SHALL drive cmd_ready = (level != FIFO_DEPTH), with no same-cycle look-through: when full, cmd_ready is 0 even if a pop occurs in that cycle.
REQ-018 SHALL pop the FIFO head into the result register on an edge where level != 0 and (res_valid == 0 or res_ready == 1).
REQ-019 SHALL give 2-edge latency into an empty unit: accept at edge E, then res_valid = 1 after edge E+1.
REQ-020 SHALL hold res_y, res_carry, res_sel and res_valid stable while res_valid = 1 and res_ready = 0.
REQ-021 SHALL, when res_valid = 1 and res_ready = 1 with the FIFO empty, clear res_valid on that edge.
REQ-022 SHALL, when res_valid = 1 and res_ready = 1 with the FIFO non-empty, load the next result on the same edge, so there is no bubble.
REQ-023 SHALL, on a simultaneous push and pop in the same edge, leave level unchanged and keep data in order.
REQ-024 SHALL use FIFO pointers that wrap modulo FIFO_DEPTH; results are produced in acceptance order.
REQ-025 SHALL increment op_count on every edge with res_valid = 1 and res_ready = 1; op_count wraps from 255 to 0.
REQ-026 SHALL compute results with 5-bit unsigned internal arithmetic; res_y = bits [3:0]; res_carry as listed per op below.
REQ-027 SHALL implement sel 000 as A+B, with res_carry = bit 4.
REQ-028 SHALL implement sel 001 as A-B, with res_carry = borrow (1 when A < B).
REQ-029 SHALL implement sel 010 as A&B, with res_carry = 0.
REQ-030 SHALL implement sel 011 as A|B, with res_carry = 0.
REQ-031 SHALL implement sel 100 as A^B, with res_carry = 0.
REQ-032 SHALL implement sel 101 as ~A, with res_carry = 0.
REQ-033 SHALL implement sel 110 as A+1, with res_carry = bit 4.
REQ-034 SHALL implement sel 111 as A-1, with res_carry = borrow (1 when A = 0).
REQ-035 SHALL ignore B for sel 101, 110 and 111.
REQ-036 SHALL leave input changes while cmd_ready = 0 with no effect.

Reset
REQ-037 SHALL, while rst_n = 0, immediately force res_valid = 0, res_y = 0, res_carry = 0, res_sel = 0, level = 0, op_count = 0, FIFO pointers = 0, and cmd_ready = 1.
REQ-038 SHALL discard all queued and in-flight commands on reset asserted mid-operation; no result from them ever appears.
REQ-039 SHALL resume operation on the first rising edge after rst_n deasserts; no command is accepted on an edge where rst_n = 0.

Verification
REQ-040 SHALL cover a basic sweep: with res_ready = 1, issue (3,5,000), (8,3,001), (C,A,010), (C,A,011), (C,A,100), (C,0,101), (7,0,110), (8,0,111) back-to-back -> y = 8, 5, 8, E, 6, 3, 8, 7, all carry = 0, in order, one per cycle after 2-edge latency, op_count = 8.
REQ-041 SHALL cover carry and borrow: (F,1,000) -> y = 0, carry = 1; (3,5,001) -> y = E, carry = 1; (F,0,110) -> y = 0, carry = 1; (0,0,111) -> y = F, carry = 1.
REQ-042 SHALL cover backpressure and full: hold res_ready = 0 and push 6 commands at DEPTH = 4 -> 5 accepted (1 in the result register, 4 queued), level = 4, cmd_ready = 0; release res_ready -> all 5 results in order, level returns to 0.
REQ-043 SHALL cover simultaneous push and pop: at level = 2, push while popping -> level stays 2, order preserved.
REQ-044 SHALL cover reset mid-stream: assert rst_n = 0 with level = 3 and res_valid = 1 -> all outputs take their reset values asynchronously; after release, a new command (2,2,000) yields y = 4 as the first result.
REQ-045 SHALL cover op_count wrap: 256 consumed results -> op_count = 0.

Source files
------------

// File: rtl/alu_cmd_unit.sv
// rtl/alu_cmd_unit.sv - command FIFO feeding a registered 4-bit ALU result stage
module alu_cmd_unit #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic [2:0] cmd_sel,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] res_y,
    output logic       res_carry,
    output logic [2:0] res_sel,
    output logic [3:0] level,
    output logic [7:0] op_count
);
    localparam int         PW      = $clog2(FIFO_DEPTH);
    localparam logic [3:0] DEPTH_L = 4'(FIFO_DEPTH);

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] sel;
    } cmd_t;

    cmd_t          mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [3:0]    level_q, level_d;
    logic          res_valid_q, res_valid_d;
    logic [3:0]    res_y_q, res_y_d;
    logic          res_carry_q, res_carry_d;
    logic [2:0]    res_sel_q, res_sel_d;
    logic [7:0]    op_count_q, op_count_d;

    logic          push, pop, consume;
    cmd_t          head;
    logic [4:0]    a5, b5, alu5;

    // cmd_ready depends only on registered level: a full FIFO never looks through a pop
    assign cmd_ready = (level_q != DEPTH_L);
    assign push      = cmd_valid && cmd_ready;
    assign consume   = res_valid_q && res_ready;
    assign pop       = (level_q != 4'd0) && (!res_valid_q || res_ready);

    assign head = mem_q[rd_ptr_q];
    assign a5   = {1'b0, head.a};
    assign b5   = {1'b0, head.b};

    // Bit 4 of the 5-bit result is the carry for adds and the borrow for subtracts
    always_comb begin
        alu5 = 5'd0;
        case (head.sel)
            3'b000: alu5 = a5 + b5;
            3'b001: alu5 = a5 - b5;
            3'b010: alu5 = {1'b0, head.a & head.b};
            3'b011: alu5 = {1'b0, head.a | head.b};
            3'b100: alu5 = {1'b0, head.a ^ head.b};
            3'b101: alu5 = {1'b0, ~head.a};
            3'b110: alu5 = a5 + 5'd1;
            3'b111: alu5 = a5 - 5'd1;
            default: alu5 = 5'd0;
        endcase
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        res_valid_d = res_valid_q;
        res_y_d     = res_y_q;
        res_carry_d = res_carry_q;
        res_sel_d   = res_sel_q;
        op_count_d  = op_count_q + {7'd0, consume};

        if (push) begin
            wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d    = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            res_valid_d = 1'b1;
            res_y_d     = alu5[3:0];
            res_carry_d = alu5[4];
            res_sel_d   = head.sel;
        end else if (consume) begin
            res_valid_d = 1'b0;
        end

        case ({push, pop})
            2'b10:   level_d = level_q + 4'd1;
            2'b01:   level_d = level_q - 4'd1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{a: cmd_a, b: cmd_b, sel: cmd_sel};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= 4'd0;
            res_valid_q <= 1'b0;
            res_y_q     <= 4'd0;
            res_carry_q <= 1'b0;
            res_sel_q   <= 3'd0;
            op_count_q  <= 8'd0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            res_valid_q <= res_valid_d;
            res_y_q     <= res_y_d;
            res_carry_q <= res_carry_d;
            res_sel_q   <= res_sel_d;
            op_count_q  <= op_count_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_y     = res_y_q;
    assign res_carry = res_carry_q;
    assign res_sel   = res_sel_q;
    assign level     = level_q;
    assign op_count  = op_count_q;
endmodule

// File: tb/tb_alu_cmd_unit.sv
// tb/tb_alu_cmd_unit.sv - scoreboard bench for alu_cmd_unit
module tb_alu_cmd_unit;
    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [2:0] cmd_sel;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_y;
    logic       res_carry;
    logic [2:0] res_sel;
    logic [3:0] level;
    logic [7:0] op_count;

    alu_cmd_unit #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_y(res_y), .res_carry(res_carry), .res_sel(res_sel),
        .level(level), .op_count(op_count)
    );

    typedef struct {
        int y;
        int c;
        int s;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   exp_ops = 0;
    logic stall_prev = 1'b0;
    int   prev_y, prev_c, prev_s;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t model(input int a, input int b, input int s);
        exp_t e;
        e.s = s;
        e.c = 0;
        case (s)
            0: begin e.y = (a + b) % 16;      e.c = (a + b > 15) ? 1 : 0; end
            1: begin e.y = (a - b + 16) % 16; e.c = (a < b) ? 1 : 0;      end
            2: e.y = a & b;
            3: e.y = a | b;
            4: e.y = a ^ b;
            5: e.y = 15 - a;
            6: begin e.y = (a + 1) % 16;      e.c = (a == 15) ? 1 : 0;    end
            default: begin e.y = (a + 15) % 16; e.c = (a == 0) ? 1 : 0;   end
        endcase
        return e;
    endfunction

    // Monitor: every transfer on the next edge is checked against the oldest expectation
    always @(negedge clk) begin
        if (rst_n) begin
            if (stall_prev) begin
                check("hold_valid", int'(res_valid), 1);
                check("hold_y", int'(res_y), prev_y);
                check("hold_carry", int'(res_carry), prev_c);
                check("hold_sel", int'(res_sel), prev_s);
            end
            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("res_y", int'(res_y), e.y);
                    check("res_carry", int'(res_carry), e.c);
                    check("res_sel", int'(res_sel), e.s);
                end
                exp_ops = (exp_ops + 1) % 256;
            end
            stall_prev = res_valid && !res_ready;
            prev_y = int'(res_y);
            prev_c = int'(res_carry);
            prev_s = int'(res_sel);
        end else begin
            stall_prev = 1'b0;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input int a, input int b, input int s);
        int n = 0;
        cmd_a = 4'(a); cmd_b = 4'(b); cmd_sel = 3'(s); cmd_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (cmd_ready) begin
                sb.push_back(model(a, b, s));
                @(posedge clk); #1;
                cmd_valid = 1'b0;
                break;
            end
            @(posedge clk); #1;
            n++;
            if (n > 200) begin
                check("send_timeout", 0, 1);
                cmd_valid = 1'b0;
                break;
            end
        end
    endtask

    task automatic drain();
        int done = 0;
        res_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (sb.size() == 0 && !res_valid) begin
                done = 1;
                break;
            end
        end
        check("drain_done", done, 1);
        check("drain_level", int'(level), 0);
        check("drain_op_count", int'(op_count), exp_ops);
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b1; res_ready = 1'b0;
        cmd_a = 4'd1; cmd_b = 4'd2; cmd_sel = 3'd0;
        @(posedge clk);
        @(negedge clk);
        check("rst_res_valid", int'(res_valid), 0);
        check("rst_res_y", int'(res_y), 0);
        check("rst_res_carry", int'(res_carry), 0);
        check("rst_res_sel", int'(res_sel), 0);
        check("rst_level", int'(level), 0);
        check("rst_op_count", int'(op_count), 0);
        check("rst_cmd_ready", int'(cmd_ready), 1);
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Sweep of every operation, back-to-back, with latency check on the first
        res_ready = 1'b1;
        send(3, 5, 0);
        check("latency_not_yet", int'(res_valid), 0);
        send(8, 3, 1);
        send(12, 10, 2); send(12, 10, 3); send(12, 10, 4);
        send(12, 0, 5); send(7, 0, 6); send(8, 0, 7);
        drain();
        check("sweep_op_count", int'(op_count), 8);

        // Carry and borrow corners
        send(15, 1, 0); send(3, 5, 1); send(15, 0, 6); send(0, 0, 7);
        drain();

        // Backpressure to full, then no look-through on the releasing edge
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(i + 1, 2 * i, i);
        cmd_a = 4'd9; cmd_b = 4'd9; cmd_sel = 3'd0; cmd_valid = 1'b1;
        @(negedge clk);
        check("full_cmd_ready", int'(cmd_ready), 0);
        check("full_level", int'(level), 4);
        check("full_res_valid", int'(res_valid), 1);
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(negedge clk);
        check("full_no_lookthrough", int'(cmd_ready), 0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("full_after_pop_level", int'(level), 3);
        @(posedge clk); #1;
        drain();

        // Simultaneous push and pop at level 2
        res_ready = 1'b0;
        send(1, 1, 0); send(6, 2, 1); send(5, 3, 4);
        @(negedge clk);
        check("simul_pre_level", int'(level), 2);
        @(posedge clk); #1;
        res_ready = 1'b1;
        cmd_a = 4'd10; cmd_b = 4'd4; cmd_sel = 3'd3; cmd_valid = 1'b1;
        @(negedge clk);
        check("simul_cmd_ready", int'(cmd_ready), 1);
        if (cmd_ready) sb.push_back(model(10, 4, 3));
        @(posedge clk); #1;
        res_ready = 1'b0; cmd_valid = 1'b0;
        @(negedge clk);
        check("simul_level", int'(level), 2);
        @(posedge clk); #1;
        drain();

        // Randomized traffic with random backpressure
        for (int i = 0; i < 300; i++) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_a = 4'($urandom_range(0, 15));
            cmd_b = 4'($urandom_range(0, 15));
            cmd_sel = 3'($urandom_range(0, 7));
            res_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (cmd_valid && cmd_ready) sb.push_back(model(int'(cmd_a), int'(cmd_b), int'(cmd_sel)));
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        drain();

        // Reset in the middle of a stalled stream
        res_ready = 1'b0;
        send(1, 2, 0); send(3, 4, 1); send(5, 6, 2); send(7, 8, 3);
        @(negedge clk);
        check("pre_reset_level", int'(level), 3);
        check("pre_reset_valid", int'(res_valid), 1);
        #2;
        rst_n = 1'b0;
        sb.delete();
        exp_ops = 0;
        #1;
        check("async_rst_res_valid", int'(res_valid), 0);
        check("async_rst_res_y", int'(res_y), 0);
        check("async_rst_res_carry", int'(res_carry), 0);
        check("async_rst_res_sel", int'(res_sel), 0);
        check("async_rst_level", int'(level), 0);
        check("async_rst_op_count", int'(op_count), 0);
        check("async_rst_cmd_ready", int'(cmd_ready), 1);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        res_ready = 1'b1;
        send(2, 2, 0);
        @(posedge clk); #1;
        check("post_reset_first_valid", int'(res_valid), 1);
        check("post_reset_first_y", int'(res_y), 4);

        // Bring the consumed count to exactly 256 since reset
        for (int i = 0; i < 255; i++)
            send($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 7));
        drain();
        check("op_count_wrap", int'(op_count), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
